fsm_pulse_seq: RTL and testbench

Pulse-train sequencer that drives the single-bit stimulus line `a_out` of a downstream level-sequenced FSM. It generates a programmed number of high/low periods with programmable lengths, reports progress and completion, and optionally checks an acknowledge line from the driven block. It sits between the top-level control and the four-phase FSM datapath.

---
 rtl/fsm_pulse_seq.sv | 203 ++++++++++++++++++++
 tb/tb_fsm_pulse_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_pulse_seq.sv
// fsm_pulse_seq: pulse-train sequencer driving the stimulus line of a
// downstream level-sequenced FSM. Emits a programmed number of high/low
// periods with programmable phase lengths and reports progress/completion.
//
// Optional build macro: FSM_PULSE_SEQ_CHECK_EN
//   When defined, each falling edge of a_out_o opens an acknowledge window
//   of TIMEOUT cycles; an expired window sets the sticky err_o flag.
//   When undefined, ack_i is ignored and err_o is tied to 0.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   start_i     in   run request, sampled in IDLE only
//   abort_i     in   stop the running sequence
//   hi_len_i    in   high-phase length (0 treated as 1), latched at start
//   lo_len_i    in   low-phase length (0 treated as 1), latched at start
//   periods_i   in   number of high+low periods, latched at start
//   ack_i       in   acknowledge from the driven block (check build only)
//   a_out_o     out  stimulus line
//   busy_o      out  sequence in progress
//   done_o      out  one-cycle completion pulse
//   err_o       out  sticky acknowledge-timeout flag
//   per_cnt_o   out  completed periods in current/last sequence
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | waiting for start, a_out=0, busy=0
// HIGH  | driving a_out=1 for max(hi_len,1) cycles
// LOW   | driving a_out=0 for max(lo_len,1) cycles
// FIN   | done pulse, returns to IDLE

module fsm_pulse_seq #(
    parameter int CNT_W   = 8,
    parameter int NUM_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] hi_len_i,
    input  logic [CNT_W-1:0] lo_len_i,
    input  logic [NUM_W-1:0] periods_i,
    input  logic             ack_i,
    output logic             a_out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [NUM_W-1:0] per_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_FIN} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hi_q;
    logic [CNT_W-1:0] lo_q;
    logic [NUM_W-1:0] per_q;
    logic [NUM_W-1:0] per_cnt_q;
    logic [NUM_W-1:0] per_cnt_d;
    logic             a_out_q;
    logic             busy_q;
    logic             done_q;

    // Phase counter is loaded with length-1 and runs down to 0, so a
    // length of 0 behaves as 1 and the maximum length never wraps.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

    assign per_cnt_d = per_cnt_q + NUM_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            per_q     <= '0;
            per_cnt_q <= '0;
            a_out_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        hi_q      <= hi_len_i;
                        lo_q      <= lo_len_i;
                        per_q     <= periods_i;
                        per_cnt_q <= '0;
                        cnt_q     <= len_m1(hi_len_i);
                        if (periods_i == '0) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_HIGH;
                            a_out_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_HIGH: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                        a_out_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= S_LOW;
                        a_out_q <= 1'b0;
                        cnt_q   <= len_m1(lo_q);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_LOW: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        per_cnt_q <= per_cnt_d;
                        if (per_cnt_d == per_q) begin
                            state_q <= S_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_HIGH;
                            a_out_q <= 1'b1;
                            cnt_q   <= len_m1(hi_q);
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign a_out_o   = a_out_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign per_cnt_o = per_cnt_q;

`ifdef FSM_PULSE_SEQ_CHECK_EN
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic          win_q;
    logic [TW-1:0] wcnt_q;
    logic          err_q;
    logic          fall_d;
    logic          start_acc_d;
    logic          abort_run_d;

    // a_out drops at the edge that ends the last HIGH cycle
    assign fall_d      = (state_q == S_HIGH) && !abort_i && (cnt_q == '0);
    assign start_acc_d = (state_q == S_IDLE) && start_i && !abort_i;
    assign abort_run_d = abort_i && ((state_q == S_HIGH) || (state_q == S_LOW));

    // The window survives FIN/IDLE; only an abort of a running sequence
    // cancels it. Expiry after the clear in the same edge wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q  <= 1'b0;
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (start_acc_d) begin
                err_q <= 1'b0;
            end
            if (fall_d) begin
                win_q  <= 1'b1;
                wcnt_q <= TW'(TIMEOUT);
            end else if (abort_run_d) begin
                win_q <= 1'b0;
            end else if (win_q) begin
                if (ack_i) begin
                    win_q <= 1'b0;
                end else if (wcnt_q == '0) begin
                    win_q <= 1'b0;
                    err_q <= 1'b1;
                end else begin
                    wcnt_q <= wcnt_q - TW'(1);
                end
            end
        end
    end

    assign err_o = err_q;
`else
    localparam int unused_timeout = TIMEOUT;
    logic unused_ack;
    assign unused_ack = ack_i;
    assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_pulse_seq.sv
// Testbench for fsm_pulse_seq: fixed vector table, hand-written corner
// sequences and randomized runs checked against a per-cycle reference
// computed directly from the period arithmetic.
module tb_fsm_pulse_seq;

    localparam int CNT_W   = 8;
    localparam int NUM_W   = 4;
    localparam int TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             ack = 1'b0;
    logic [CNT_W-1:0] hi_len = '0;
    logic [CNT_W-1:0] lo_len = '0;
    logic [NUM_W-1:0] periods = '0;
    logic             a_out;
    logic             busy;
    logic             done;
    logic             err;
    logic [NUM_W-1:0] per_cnt;

    int checks   = 0;
    int failures = 0;

    fsm_pulse_seq #(.CNT_W(CNT_W), .NUM_W(NUM_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .abort_i   (abort),
        .hi_len_i  (hi_len),
        .lo_len_i  (lo_len),
        .periods_i (periods),
        .ack_i     (ack),
        .a_out_o   (a_out),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .per_cnt_o (per_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected {a_out, busy, done, err, per_cnt} in cycle k after the start
    // cycle. ka = cycle in which abort is held (0 = none).
    function automatic logic [7:0] model(input int k, input int h, input int l,
                                         input int p, input int ka);
        int   he, le, len, pc;
        logic a, b, d;
        he  = (h == 0) ? 1 : h;
        le  = (l == 0) ? 1 : l;
        len = he + le;
        a = 1'b0; b = 1'b0; d = 1'b0;
        if (ka > 0 && k > ka) begin
            pc = (ka - 1) / len;
        end else if (k <= p * len) begin
            a  = ((k - 1) % len) < he;
            b  = 1'b1;
            pc = (k - 1) / len;
        end else begin
            d  = (k == p * len + 1);
            pc = p;
        end
        return {a, b, d, 1'b0, 4'(pc)};
    endfunction

    task automatic run(input int h, input int l, input int p, input int ka,
                       input bit noise, output int done_k, output int pc_end);
        int he, le, len, endk;
        he   = (h == 0) ? 1 : h;
        le   = (l == 0) ? 1 : l;
        len  = he + le;
        endk = (ka != 0) ? ka : p * len + 1;
        @(negedge clk);
        start   = 1'b1;
        abort   = 1'b0;
        ack     = 1'b1;
        hi_len  = CNT_W'(h);
        lo_len  = CNT_W'(l);
        periods = NUM_W'(p);
        done_k  = 0;
        for (int k = 1; k <= endk + 2; k++) begin
            @(negedge clk);
            chk($sformatf("trace h=%0d l=%0d p=%0d ka=%0d k=%0d", h, l, p, ka, k),
                {a_out, busy, done, err, per_cnt}, model(k, h, l, p, ka));
            if (done && done_k == 0) done_k = k;
            start = 1'b0;
            abort = (k == ka);
            if (noise && k <= endk) begin
                start   = 1'($urandom_range(0, 1));
                hi_len  = CNT_W'($urandom);
                lo_len  = CNT_W'($urandom);
                periods = NUM_W'($urandom);
            end
        end
        pc_end = int'(per_cnt);
        start  = 1'b0;
        abort  = 1'b0;
    endtask

    typedef struct {
        int hi;
        int lo;
        int per;
        int ka;
        int done_k;
        int pc;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int dk, pc;
        tbl[0] = '{hi: 3,   lo: 2, per: 2,  ka: 0, done_k: 11,  pc: 2};
        tbl[1] = '{hi: 0,   lo: 0, per: 1,  ka: 0, done_k: 3,   pc: 1};
        tbl[2] = '{hi: 5,   lo: 5, per: 0,  ka: 0, done_k: 1,   pc: 0};
        tbl[3] = '{hi: 3,   lo: 2, per: 3,  ka: 7, done_k: 0,   pc: 1};
        tbl[4] = '{hi: 255, lo: 0, per: 1,  ka: 0, done_k: 257, pc: 1};
        tbl[5] = '{hi: 1,   lo: 4, per: 15, ka: 0, done_k: 76,  pc: 15};
        tbl[6] = '{hi: 2,   lo: 0, per: 2,  ka: 7, done_k: 7,   pc: 2};

        // reset held with start asserted
        rst_n = 1'b0;
        start = 1'b1;
        periods = 4'd2;
        hi_len = 8'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset cycle %0d", i), {a_out, busy, done, err, per_cnt}, 32'h0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ack = ~ack;
        end
        @(negedge clk);
        chk("idle ack toggle", {a_out, busy, done, err, per_cnt}, 32'h0);

        // vector table
        for (int i = 0; i < 7; i++) begin
            run(tbl[i].hi, tbl[i].lo, tbl[i].per, tbl[i].ka, (i % 2) == 1, dk, pc);
            chk($sformatf("tbl%0d done cycle", i), dk, tbl[i].done_k);
            chk($sformatf("tbl%0d per_cnt", i), pc, tbl[i].pc);
        end

        // abort wins over simultaneous start in IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        hi_len = 8'd2;
        periods = 4'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            chk($sformatf("start+abort idle c%0d", i), {a_out, busy, done}, 32'h0);
        end

        // reset in the middle of a sequence
        @(negedge clk);
        start = 1'b1;
        hi_len = 8'd3;
        lo_len = 8'd2;
        periods = 4'd3;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mid per_cnt", {busy, per_cnt}, {27'h0, 1'b1, 4'd1});
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid reset outputs", {a_out, busy, done, err, per_cnt}, 32'h0);
        rst_n = 1'b1;

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            int h, l, p, ka, len;
            h   = $urandom_range(0, 6);
            l   = $urandom_range(0, 6);
            p   = $urandom_range(0, 5);
            len = ((h == 0) ? 1 : h) + ((l == 0) ? 1 : l);
            ka  = 0;
            if (p > 0 && $urandom_range(0, 3) == 0) ka = $urandom_range(1, p * len);
            run(h, l, p, ka, 1'b1, dk, pc);
            chk($sformatf("rand%0d per_cnt", r), pc, (ka != 0) ? (ka - 1) / len : p);
        end

`ifdef FSM_PULSE_SEQ_CHECK_EN
        // ack two cycles after each falling edge: no error
        @(negedge clk);
        start = 1'b1;
        hi_len = 8'd1;
        lo_len = 8'd3;
        periods = 4'd2;
        ack = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            ack = (k == 4 || k == 8);
        end
        chk("ack ok err", err, 0);
        // no ack after the second falling edge
        start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 10) chk("timeout err before expiry", err, 0);
            if (k == 11) chk("timeout err at expiry", err, 1);
            if (k == 14) chk("timeout err sticky", err, 1);
            start = 1'b0;
            ack = (k == 4);
        end
        start = 1'b1;
        periods = 4'd0;
        @(negedge clk);
        start = 1'b0;
        chk("err cleared by start", {done, err}, 32'h2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
